// File: rtl/dmem_mmio.sv
// Data-port responder: word-addressed RAM plus an MMIO page holding a cycle
// counter and a byte-wide transmit FIFO that drains over valid/ready.
module dmem_mmio #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [1:0]  memwrite,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = FW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_WORD = 2'b01;
  localparam logic [1:0] MW_HALF = 2'b10;
  localparam logic [1:0] MW_BYTE = 2'b11;

  localparam logic [7:0] OFF_CYCLE  = 8'h00;
  localparam logic [7:0] OFF_TXDATA = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;

  logic [31:0]   mem_q [DEPTH];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [31:0]   cycle_q, cycle_d;
  logic [FW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic          is_mmio;
  logic [7:0]    offset;
  logic [AW-1:0] ram_idx;
  logic          ram_we;
  logic [3:0]    lane_mask;
  logic [31:0]   lane_data;
  logic          fifo_full, fifo_empty;
  logic          push_req, push_ok, pop, ovf_set, ovf_clr, cycle_load;

  assign is_mmio = (addr[31:8] == MMIO_BASE[31:8]);
  assign offset  = addr[7:0];
  assign ram_idx = addr[AW+1:2];
  assign ram_we  = !is_mmio && (memwrite != MW_NONE);

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign tx_valid   = !fifo_empty;
  assign tx_data    = fifo_q[rd_ptr_q];

  assign pop        = tx_valid && tx_ready;
  assign push_req   = is_mmio && (offset == OFF_TXDATA) && (memwrite != MW_NONE);
  // A push into a full FIFO only lands if the head leaves in the same cycle.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign ovf_set    = push_req && fifo_full && !pop;
  assign ovf_clr    = is_mmio && (offset == OFF_STATUS) && (memwrite == MW_WORD) && writedata[2];
  assign cycle_load = is_mmio && (offset == OFF_CYCLE) && (memwrite == MW_WORD);

  // Little-endian lane steering for stores.
  always_comb begin
    lane_mask = 4'b0000;
    lane_data = writedata;
    case (memwrite)
      MW_WORD: lane_mask = 4'b1111;
      MW_HALF: begin
        lane_mask = addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{writedata[15:0]}};
      end
      MW_BYTE: begin
        lane_mask = 4'b0001 << addr[1:0];
        lane_data = {4{writedata[7:0]}};
      end
      default: lane_mask = 4'b0000;
    endcase
  end

  // RAM keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_mask[i]) mem_q[ram_idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    cycle_d  = cycle_load ? writedata : cycle_q + 32'd1;
    rd_ptr_d = pop     ? rd_ptr_q + FW'(1) : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + FW'(1) : wr_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A new overflow outranks a same-cycle clear.
    ovf_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cycle_q  <= cycle_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
    end else if (push_ok) begin
      fifo_q[wr_ptr_q] <= writedata[7:0];
    end
  end

  always_comb begin
    readdata = '0;
    if (is_mmio) begin
      case (offset)
        OFF_CYCLE:  readdata = cycle_q;
        OFF_STATUS: readdata = {16'b0, 8'(count_q), 5'b0, ovf_q, fifo_full, fifo_empty};
        default:    readdata = '0;
      endcase
    end else begin
      readdata = mem_q[ram_idx];
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed RAM/MMIO accesses plus a
// scoreboard that predicts every byte leaving the transmit FIFO.
module tb_dmem_mmio;

  localparam logic [31:0] A_CYCLE  = 32'hFFFF0000;
  localparam logic [31:0] A_TXDATA = 32'hFFFF0004;
  localparam logic [31:0] A_STATUS = 32'hFFFF0008;
  localparam logic [31:0] A_UNUSED = 32'hFFFF000C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [1:0]  memwrite = 2'b00;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] sb_q [$];
  logic [7:0] exp_b;

  dmem_mmio #(.DEPTH(256), .FIFO_DEPTH(8), .MMIO_BASE(32'hFFFF0000)) dut (
    .clk(clk), .reset(reset), .addr(addr), .memwrite(memwrite),
    .writedata(writedata), .readdata(readdata), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [1:0] code, input logic [31:0] d);
    addr = a; memwrite = code; writedata = d;
    @(posedge clk); #1;
    memwrite = 2'b00;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; #1;
    chk(tag, readdata, exp);
  endtask

  task automatic push_tx(input logic [7:0] b, input bit kept);
    wr(A_TXDATA, 2'b11, {24'h0, b});
    if (kept) sb_q.push_back(b);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", 32'(sb_q.size()), 32'd0);
  endtask

  // Each accepted head byte must match the next predicted byte.
  always @(negedge clk) begin
    if (!reset && tx_valid && tx_ready) begin
      if (sb_q.size() == 0) begin
        chk("tx_unexpected_pop", {31'd0, tx_valid}, 32'd0);
      end else begin
        exp_b = sb_q.pop_front();
        chk("tx_data", {24'd0, tx_data}, {24'd0, exp_b});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] m_addr [6];
    logic [31:0] m_data [6];

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    rd("rst_cycle", A_CYCLE, 32'd0);
    rd("rst_status", A_STATUS, 32'h00000001);

    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rd("cycle_10", A_CYCLE, 32'd10);

    wr(A_CYCLE, 2'b01, 32'hFFFFFFFE);
    rd("cycle_load", A_CYCLE, 32'hFFFFFFFE);
    @(posedge clk);
    @(posedge clk);
    #1;
    rd("cycle_wrap", A_CYCLE, 32'h00000000);
    wr(A_CYCLE, 2'b11, 32'h00000055);
    rd("cycle_subword_ignored", A_CYCLE, 32'h00000001);

    wr(A_UNUSED, 2'b01, 32'h12345678);
    rd("mmio_unused", A_UNUSED, 32'd0);
    rd("mmio_txdata_read", A_TXDATA, 32'd0);

    wr(32'h40, 2'b01, 32'h11223344);
    wr(32'h41, 2'b11, 32'h000000AA);
    wr(32'h42, 2'b10, 32'h0000BEEF);
    rd("ram_lanes", 32'h40, 32'hBEEFAA44);
    wr(32'h80, 2'b01, 32'h0);
    wr(32'h81, 2'b10, 32'hFFFF1234);
    rd("ram_half_low", 32'h80, 32'h00001234);
    wr(32'h83, 2'b11, 32'h000000C3);
    rd("ram_byte_top", 32'h80, 32'hC3001234);
    wr(32'h400, 2'b01, 32'hDEADBEEF);
    rd("ram_wrap", 32'h000, 32'hDEADBEEF);

    for (int i = 0; i < 6; i++) begin
      m_addr[i] = 32'((40 + i * 3 + $urandom_range(0, 2)) * 4);
      m_data[i] = $urandom;
      wr(m_addr[i], 2'b01, m_data[i]);
    end
    for (int i = 0; i < 6; i++) rd("ram_rand", m_addr[i], m_data[i]);

    tx_ready = 1'b0;
    push_tx(8'h41, 1'b1);
    push_tx(8'h42, 1'b1);
    push_tx(8'h43, 1'b1);
    rd("fifo_status3", A_STATUS, 32'h00000300);
    tx_ready = 1'b1;
    drain();
    chk("fifo_empty_valid", {31'd0, tx_valid}, 32'd0);
    rd("fifo_status_empty", A_STATUS, 32'h00000001);

    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) push_tx(8'(8'h50 + i), i < 8);
    rd("ovf_status", A_STATUS, 32'h00000806);
    wr(A_STATUS, 2'b01, 32'h00000004);
    rd("ovf_cleared", A_STATUS, 32'h00000802);
    tx_ready = 1'b1;
    push_tx(8'h60, 1'b1);
    rd("full_push_pop", A_STATUS, 32'h00000802);
    drain();
    rd("ovf_drained", A_STATUS, 32'h00000001);

    tx_ready = 1'b0;
    push_tx(8'h71, 1'b1);
    push_tx(8'h72, 1'b1);
    push_tx(8'h73, 1'b1);
    rd("pre_reset_status", A_STATUS, 32'h00000300);
    #2 reset = 1'b1;
    #1;
    chk("async_flush_valid", {31'd0, tx_valid}, 32'd0);
    sb_q.delete();
    rd("in_reset_status", A_STATUS, 32'h00000001);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    rd("post_reset_status", A_STATUS, 32'h00000001);
    rd("post_reset_ram", 32'h40, 32'hBEEFAA44);
    chk("post_reset_tx_data", {24'd0, tx_data}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
